vector_loader: RTL and testbench



---
 rtl/vector_loader.sv | 141 ++++++++++++++
 tb/tb_vector_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_loader.sv
// Serial-to-parallel staging for the dot-product stage: packs DIM (a, b) element pairs into flat vectors.
// Optional build macro ZERO_PAD_EN lets InLast end a short vector early, zero-filling the remaining elements.
module vector_loader #(
    parameter int DIM          = 8,
    parameter int A_DATA_WIDTH = 32,
    parameter int B_DATA_WIDTH = 32
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [A_DATA_WIDTH-1:0]       InA,
    input  logic [B_DATA_WIDTH-1:0]       InB,
    input  logic                          InLast,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [DIM*A_DATA_WIDTH-1:0]   OutA,
    output logic [DIM*B_DATA_WIDTH-1:0]   OutB
);

    localparam int CW = $clog2(DIM + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

    localparam logic FILL = 1'b0;
    localparam logic HOLD = 1'b1;

    logic                        state_reg, state_next;
    logic [CW-1:0]               count_reg, count_next;
    logic [DIM*A_DATA_WIDTH-1:0] fill_a_reg, fill_a_next;
    logic [DIM*B_DATA_WIDTH-1:0] fill_b_reg, fill_b_next;
    logic [DIM*A_DATA_WIDTH-1:0] out_a_reg, out_a_next;
    logic [DIM*B_DATA_WIDTH-1:0] out_b_reg, out_b_next;
    logic                        out_valid_reg, out_valid_next;

    logic in_fire;
    logic slot_free;
    logic pad_beat;
    logic last_beat;

    assign in_fire   = InValid && (state_reg == FILL);
    assign slot_free = !out_valid_reg || OutReady;

`ifdef ZERO_PAD_EN
    assign pad_beat = InLast;
`else
    logic unused_in_last;
    assign unused_in_last = InLast;
    assign pad_beat       = 1'b0;
`endif

    assign last_beat = in_fire && ((count_reg == LAST_IDX) || pad_beat);

    // Next fill contents include the current beat, so a completing vector can
    // bypass straight into the output register. Elements past a short final
    // beat are zeroed so a held short vector is already padded.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_elem
            localparam logic [CW-1:0] IDX = CW'(gi);
            logic write_en;
            logic pad_zero;

            assign write_en = in_fire && (count_reg == IDX);
            assign pad_zero = last_beat && (IDX > count_reg);

            assign fill_a_next[gi*A_DATA_WIDTH +: A_DATA_WIDTH] =
                write_en ? InA :
                pad_zero ? '0  : fill_a_reg[gi*A_DATA_WIDTH +: A_DATA_WIDTH];

            assign fill_b_next[gi*B_DATA_WIDTH +: B_DATA_WIDTH] =
                write_en ? InB :
                pad_zero ? '0  : fill_b_reg[gi*B_DATA_WIDTH +: B_DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        out_a_next     = out_a_reg;
        out_b_next     = out_b_reg;
        out_valid_next = out_valid_reg;

        if (out_valid_reg && OutReady) begin
            out_valid_next = 1'b0;
        end

        if (in_fire) begin
            count_next = last_beat ? '0 : count_reg + 1'b1;
        end

        case (state_reg)
            FILL: begin
                if (last_beat) begin
                    if (slot_free) begin
                        out_a_next     = fill_a_next;
                        out_b_next     = fill_b_next;
                        out_valid_next = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    out_a_next     = fill_a_reg;
                    out_b_next     = fill_b_reg;
                    out_valid_next = 1'b1;
                    state_next     = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg     <= FILL;
            count_reg     <= '0;
            fill_a_reg    <= '0;
            fill_b_reg    <= '0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            fill_a_reg    <= fill_a_next;
            fill_b_reg    <= fill_b_next;
            out_a_reg     <= out_a_next;
            out_b_reg     <= out_b_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign InReady  = (state_reg == FILL);
    assign OutValid = out_valid_reg;
    assign OutA     = out_a_reg;
    assign OutB     = out_b_reg;

endmodule

// File: tb/tb_vector_loader.sv
// Self-checking bench for vector_loader (DIM=4, 8-bit elements) with a scoreboard of expected vectors.
// Build with ZERO_PAD_EN defined to exercise the short-vector path.
module tb_vector_loader;

    localparam int DIM = 4;
    localparam int AW  = 8;
    localparam int BW  = 8;

    logic              Clock    = 1'b0;
    logic              Resetn   = 1'b0;
    logic              InValid  = 1'b0;
    logic              InReady;
    logic [AW-1:0]     InA      = '0;
    logic [BW-1:0]     InB      = '0;
    logic              InLast   = 1'b0;
    logic              OutValid;
    logic              OutReady = 1'b0;
    logic [DIM*AW-1:0] OutA;
    logic [DIM*BW-1:0] OutB;

    vector_loader #(
        .DIM          (DIM),
        .A_DATA_WIDTH (AW),
        .B_DATA_WIDTH (BW)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .InValid  (InValid),
        .InReady  (InReady),
        .InA      (InA),
        .InB      (InB),
        .InLast   (InLast),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutA     (OutA),
        .OutB     (OutB)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [63:0]       sb_q[$];
    logic [DIM*AW-1:0] acc_a;
    logic [DIM*BW-1:0] acc_b;
    logic [63:0]       sb_exp;
    int                acc_k   = 0;
    int                vec_cnt = 0;
    logic              acc_done;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
        InValid = 1'b1;
        InA     = a;
        InB     = b;
        InLast  = last;
        @(posedge Clock);
        #1;
    endtask

    // Scoreboard: sample handshakes half a cycle before the edge that completes them.
    always @(negedge Clock) begin
        if (!Resetn) begin
            sb_q.delete();
            acc_k = 0;
            acc_a = '0;
            acc_b = '0;
        end else begin
            if (OutValid && OutReady) begin
                check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    sb_exp = sb_q.pop_front();
                    check_val("out_vec", {OutA, OutB}, sb_exp);
                    $display("vector %0d: a=%h b=%h", vec_cnt, OutA, OutB);
                    vec_cnt++;
                end
            end
            if (InValid && InReady) begin
                if (acc_k == 0) begin
                    acc_a = '0;
                    acc_b = '0;
                end
                acc_a[acc_k*AW +: AW] = InA;
                acc_b[acc_k*BW +: BW] = InB;
                acc_done = (acc_k == DIM - 1);
`ifdef ZERO_PAD_EN
                acc_done = acc_done || InLast;
`endif
                if (acc_done) begin
                    sb_q.push_back({acc_a, acc_b});
                    acc_k = 0;
                end else begin
                    acc_k++;
                end
            end
        end
    end

    initial begin
        int hi_cnt;
        int rdy_low;

        // Reset state
        step(2);
        check_val("rst_inready", 64'(InReady), 64'd1);
        check_val("rst_outvalid", 64'(OutValid), 64'd0);
        Resetn = 1'b1;
        step(1);
        check_val("post_rst_outa", 64'(OutA), 64'd0);
        check_val("post_rst_outb", 64'(OutB), 64'd0);
        check_val("post_rst_outvalid", 64'(OutValid), 64'd0);
        check_val("post_rst_inready", 64'(InReady), 64'd1);

        // Single vector, latency and packing order
        OutReady = 1'b1;
        beat(8'd1, 8'd5, 1'b0);
        beat(8'd2, 8'd6, 1'b0);
        beat(8'd3, 8'd7, 1'b0);
        beat(8'd4, 8'd8, 1'b0);
        InValid = 1'b0;
        check_val("t1_outvalid", 64'(OutValid), 64'd1);
        check_val("t1_outa", 64'(OutA), 64'h04030201);
        check_val("t1_outb", 64'(OutB), 64'h08070605);
        step(1);
        check_val("t1_outvalid_drop", 64'(OutValid), 64'd0);

        // Continuous streaming of three vectors
        hi_cnt  = 0;
        rdy_low = 0;
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < DIM; k++) begin
                beat(8'(16*v + k + 1), 8'(8'h80 + 16*v + k), 1'b0);
                if (!InReady) rdy_low++;
                if (OutValid) hi_cnt++;
            end
        end
        InValid = 1'b0;
        check_val("t2_inready_never_low", 64'(rdy_low), 64'd0);
        check_val("t2_outvalid_pulses", 64'(hi_cnt), 64'd3);
        step(1);
        check_val("t2_idle_outvalid", 64'(OutValid), 64'd0);

        // Downstream stall: second vector fills, then backpressure
        OutReady = 1'b0;
        for (int i = 0; i < 2*DIM; i++) begin
            beat(8'(8'h21 + i), 8'(8'h41 + i), 1'b0);
            if (i == DIM - 1) check_val("t3_first_valid", 64'(OutValid), 64'd1);
        end
        InValid = 1'b0;
        check_val("t3_inready_low", 64'(InReady), 64'd0);
        check_val("t3_hold_outa", 64'(OutA), 64'h24232221);
        check_val("t3_hold_outb", 64'(OutB), 64'h44434241);
        step(2);
        check_val("t3_stable_outa", 64'(OutA), 64'h24232221);
        check_val("t3_stable_valid", 64'(OutValid), 64'd1);
        check_val("t3_still_blocked", 64'(InReady), 64'd0);
        OutReady = 1'b1;
        step(1);
        check_val("t3_second_valid", 64'(OutValid), 64'd1);
        check_val("t3_second_outa", 64'(OutA), 64'h28272625);
        check_val("t3_second_outb", 64'(OutB), 64'h48474645);
        check_val("t3_inready_back", 64'(InReady), 64'd1);
        step(1);
        check_val("t3_drain", 64'(OutValid), 64'd0);

        // Reset mid-fill discards the partial vector
        beat(8'h51, 8'h61, 1'b0);
        beat(8'h52, 8'h62, 1'b0);
        InValid = 1'b0;
        Resetn  = 1'b0;
        #1;
        check_val("t4_rst_outvalid", 64'(OutValid), 64'd0);
        check_val("t4_rst_inready", 64'(InReady), 64'd1);
        step(2);
        Resetn = 1'b1;
        step(1);
        check_val("t4_outa_zero", 64'(OutA), 64'd0);
        check_val("t4_outb_zero", 64'(OutB), 64'd0);
        check_val("t4_outvalid", 64'(OutValid), 64'd0);
        check_val("t4_inready", 64'(InReady), 64'd1);
        for (int i = 0; i < DIM; i++) beat(8'(8'h71 + i), 8'(8'h81 + i), 1'b0);
        InValid = 1'b0;
        check_val("t4_clean_outa", 64'(OutA), 64'h74737271);
        check_val("t4_clean_outb", 64'(OutB), 64'h84838281);
        step(1);

        // Short vector via InLast
        beat(8'h09, 8'h01, 1'b0);
        beat(8'h07, 8'h02, 1'b1);
        InValid = 1'b0;
        InLast  = 1'b0;
`ifdef ZERO_PAD_EN
        check_val("t5_pad_valid", 64'(OutValid), 64'd1);
        check_val("t5_pad_outa", 64'(OutA), 64'h00000709);
        check_val("t5_pad_outb", 64'(OutB), 64'h00000201);
        step(1);
`else
        check_val("t5_nopad_valid", 64'(OutValid), 64'd0);
        step(1);
        check_val("t5_nopad_wait", 64'(OutValid), 64'd0);
        beat(8'h0B, 8'h03, 1'b0);
        beat(8'h0C, 8'h04, 1'b0);
        InValid = 1'b0;
        check_val("t5_full_valid", 64'(OutValid), 64'd1);
        check_val("t5_full_outa", 64'(OutA), 64'h0C0B0709);
        check_val("t5_full_outb", 64'(OutB), 64'h04030201);
        step(1);
`endif

        // Reset while in HOLD with a vector waiting
        OutReady = 1'b0;
        for (int i = 0; i < 2*DIM; i++) beat(8'(8'h90 + i), 8'(8'hA0 + i), 1'b0);
        InValid = 1'b0;
        check_val("t6_hold_inready", 64'(InReady), 64'd0);
        check_val("t6_hold_valid", 64'(OutValid), 64'd1);
        Resetn = 1'b0;
        #1;
        check_val("t6_async_valid", 64'(OutValid), 64'd0);
        check_val("t6_async_inready", 64'(InReady), 64'd1);
        check_val("t6_async_outa", 64'(OutA), 64'd0);
        step(2);
        Resetn = 1'b1;
        step(1);
        check_val("t6_post_valid", 64'(OutValid), 64'd0);
        check_val("t6_sb_flushed", 64'(sb_q.size()), 64'd0);

        // One more vector after HOLD reset, then confirm everything drained
        OutReady = 1'b1;
        for (int i = 0; i < DIM; i++) beat(8'(8'hC1 + i), 8'(8'hD1 + i), 1'b0);
        InValid = 1'b0;
        check_val("t6_after_outa", 64'(OutA), 64'hC4C3C2C1);
        step(2);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
